// File: rtl/mdio_phy_emu.sv
// mdio_phy_emu: Clause 22 MDIO slave presenting a virtual PHY register set
module mdio_phy_emu #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mdc,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_t,
  input  logic       link,
  input  logic [1:0] speed,
  input  logic       duplex
);
  typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, DATA} state_t;
  state_t      st_q, st_d;
  logic [1:0]  mdc_q, mdio_q;
  logic        mdc_prev_q, smp_q;
  logic [5:0]  pre_q, pre_d;
  logic [4:0]  cnt_q, cnt_d, phy_q, phy_d, reg_q, reg_d;
  logic        op0_q, op0_d, rd_q, rd_d, o_q, o_d, t_q, t_d;
  logic [15:0] sh_q, sh_d, bmcr_q, bmcr_d, anar_q, anar_d, rdata, wdata;
  logic        b, match;
  assign b      = mdio_q[1];
  assign match  = phy_q == PHY_ADDR;
  assign wdata  = {sh_q[14:0], b};
  assign mdio_o = o_q;
  assign mdio_t = t_q;
  assign rdata  = reg_q == 5'd0  ? bmcr_q :
                  reg_q == 5'd1  ? (16'h7949 | {10'd0, link, 2'd0, link, 2'd0}) :
                  reg_q == 5'd2  ? PHY_ID1 :
                  reg_q == 5'd3  ? PHY_ID2 :
                  reg_q == 5'd4  ? anar_q :
                  reg_q == 5'd5  ? (link ? 16'h41E1 : 16'd0) :
                  reg_q == 5'd17 ? {speed, duplex, 1'b0, link, link, 10'd0} : 16'd0;
  always_comb begin
    st_d   = st_q;
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    op0_d  = op0_q;
    rd_d   = rd_q;
    phy_d  = phy_q;
    reg_d  = reg_q;
    sh_d   = sh_q;
    bmcr_d = bmcr_q;
    anar_d = anar_q;
    o_d    = o_q;
    t_d    = t_q;
    if (smp_q) begin
      case (st_q)
        IDLE: begin
          cnt_d = 5'd0;
          pre_d = b ? (pre_q == 6'd32 ? 6'd32 : pre_q + 6'd1) : 6'd0;
          st_d  = (!b && pre_q == 6'd32) ? ST2 : IDLE;
        end
        ST2: st_d = b ? OP : IDLE;
        OP: begin
          op0_d = b;
          rd_d  = op0_q & ~b;
          cnt_d = cnt_q == 5'd0 ? 5'd1 : 5'd0;
          st_d  = cnt_q == 5'd0 ? OP : ((op0_q ^ b) ? PHYAD : IDLE);
        end
        PHYAD: begin
          phy_d = {phy_q[3:0], b};
          cnt_d = cnt_q == 5'd4 ? 5'd0 : cnt_q + 5'd1;
          st_d  = cnt_q == 5'd4 ? REGAD : PHYAD;
        end
        REGAD: begin
          reg_d = {reg_q[3:0], b};
          cnt_d = cnt_q == 5'd4 ? 5'd0 : cnt_q + 5'd1;
          st_d  = cnt_q == 5'd4 ? TA : REGAD;
        end
        TA: begin
          cnt_d = cnt_q == 5'd0 ? 5'd1 : 5'd0;
          st_d  = cnt_q == 5'd0 ? TA : DATA;
          if (cnt_q == 5'd0 && rd_q && match) begin
            sh_d = rdata;
            t_d  = 1'b0;
            o_d  = 1'b0;
          end else if (cnt_q != 5'd0 && !t_q) begin
            sh_d = {sh_q[14:0], 1'b0};
            o_d  = sh_q[15];
          end
        end
        DATA: begin
          sh_d  = wdata;
          o_d   = t_q ? o_q : sh_q[15];
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            st_d  = IDLE;
            cnt_d = 5'd0;
            pre_d = 6'd0;
            t_d   = 1'b1;
            o_d   = 1'b0;
            if (!rd_q && match && reg_q == 5'd0) begin
              bmcr_d = wdata[15] ? 16'h1140 : (wdata & 16'h7DFF);
              anar_d = wdata[15] ? 16'h01E1 : anar_q;
            end
            if (!rd_q && match && reg_q == 5'd4) anar_d = wdata;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q      <= 2'b00;
      mdio_q     <= 2'b00;
      mdc_prev_q <= 1'b0;
      smp_q      <= 1'b0;
      st_q       <= IDLE;
      pre_q      <= 6'd0;
      cnt_q      <= 5'd0;
      op0_q      <= 1'b0;
      rd_q       <= 1'b0;
      phy_q      <= 5'd0;
      reg_q      <= 5'd0;
      sh_q       <= 16'd0;
      bmcr_q     <= 16'h1140;
      anar_q     <= 16'h01E1;
      o_q        <= 1'b0;
      t_q        <= 1'b1;
    end else begin
      mdc_q      <= {mdc_q[0], mdc};
      mdio_q     <= {mdio_q[0], mdio_i};
      mdc_prev_q <= mdc_q[1];
      smp_q      <= mdc_q[1] & ~mdc_prev_q;
      st_q       <= st_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      op0_q      <= op0_d;
      rd_q       <= rd_d;
      phy_q      <= phy_d;
      reg_q      <= reg_d;
      sh_q       <= sh_d;
      bmcr_q     <= bmcr_d;
      anar_q     <= anar_d;
      o_q        <= o_d;
      t_q        <= t_d;
    end
  end
endmodule

// File: tb/tb_mdio_phy_emu.sv
// tb_mdio_phy_emu: randomized MDIO master driving the PHY emulator against a register model
module tb_mdio_phy_emu;
  logic        clk = 1'b0, rst = 1'b1, mdc = 1'b0, mdio_i = 1'b1;
  logic        link = 1'b0, duplex = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic        mdio_o, mdio_t;
  int          checks = 0, errors = 0;
  logic [15:0] bmcr_m = 16'h1140, anar_m = 16'h01E1;
  logic [4:0]  ras [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd17, 5'd9};
  mdio_phy_emu dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_t(mdio_t),
    .link(link), .speed(speed), .duplex(duplex)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model_read(input logic [4:0] ra);
    case (ra)
      5'd0:    return bmcr_m;
      5'd1:    return link ? 16'h796D : 16'h7949;
      5'd2:    return 16'h0141;
      5'd3:    return 16'h0CC2;
      5'd4:    return anar_m;
      5'd5:    return link ? 16'h41E1 : 16'h0000;
      5'd17:   return 16'(speed * 16'h4000 + duplex * 16'h2000 + link * 16'h0C00);
      default: return 16'h0000;
    endcase
  endfunction
  task automatic model_write(input logic [4:0] ra, input logic [15:0] wd);
    if (ra == 5'd0 && wd[15]) begin
      bmcr_m = 16'h1140;
      anar_m = 16'h01E1;
    end else if (ra == 5'd0) bmcr_m = wd & ~16'h8200;
    else if (ra == 5'd4) anar_m = wd;
  endtask
  task automatic mdc_bit(input logic bv, output logic t, output logic o);
    @(negedge clk);
    mdc = 1'b0;
    mdio_i = bv;
    repeat (4) @(negedge clk);
    t = mdio_t;
    o = mdio_o;
    @(negedge clk);
    mdc = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input int flip_at, input int rst_at);
    logic t, o, hiz;
    logic [17:0] ts, os, tail;
    logic [13:0] hdr;
    logic [15:0] exp, got;
    bit rd, valid, drive;
    rd    = op == 2'b10;
    valid = pre >= 32 && (op == 2'b10 || op == 2'b01);
    drive = valid && rd && pa == 5'd1;
    exp   = model_read(ra);
    hdr   = {2'b01, op, pa, ra};
    tail  = rd ? 18'h3FFFF : {2'b10, wd};
    hiz   = 1'b1;
    mdc_bit(1'b0, t, o);
    hiz &= t;
    for (int i = 0; i < pre; i++) begin
      mdc_bit(1'b1, t, o);
      hiz &= t;
    end
    for (int i = 13; i >= 0; i--) begin
      mdc_bit(hdr[i], t, o);
      hiz &= t;
    end
    for (int j = 0; j < 18; j++) begin
      if (j == flip_at) link = ~link;
      mdc_bit(tail[17-j], t, o);
      ts[j] = t;
      os[j] = o;
      if (j == rst_at) begin
        check("pre_rst_drive", 16'(mdio_t), drive ? 16'd0 : 16'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_t", 16'(mdio_t), 16'd1);
        check("rst_mid_o", 16'(mdio_o), 16'd0);
        rst = 1'b0;
        bmcr_m = 16'h1140;
        anar_m = 16'h01E1;
        return;
      end
    end
    if (drive) begin
      for (int k = 0; k < 16; k++) got[15-k] = os[k+2];
      check("hdr_hiz", 16'(hiz), 16'd1);
      check("ta1_hiz", 16'(ts[0]), 16'd1);
      check("ta2_zero", 16'({ts[1], os[1]}), 16'd0);
      check("data_drv", 16'(|ts[17:2]), 16'd0);
      check("rd_data", got, exp);
    end else check("no_drive", 16'(hiz & (&ts)), 16'd1);
    check("release", 16'(mdio_t), 16'd1);
    if (valid && !rd && pa == 5'd1) model_write(ra, wd);
  endtask
  initial begin
    int pre, flip;
    logic [1:0] op;
    logic [4:0] pa, ra;
    logic [15:0] wd;
    repeat (3) @(negedge clk);
    check("rst_t", 16'(mdio_t), 16'd1);
    check("rst_o", 16'(mdio_o), 16'd0);
    rst = 1'b0;
    frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, -1);
    frame(32, 2'b01, 5'd1, 5'd4, 16'h0DE1, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, -1);
    frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, -1);
    frame(32, 2'b01, 5'd1, 5'd0, 16'h0340, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, -1);
    frame(32, 2'b10, 5'd2, 5'd2, 16'h0, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd3, 16'h0, -1, -1);
    frame(31, 2'b10, 5'd1, 5'd2, 16'h0, -1, -1);
    frame(32, 2'b11, 5'd1, 5'd4, 16'h1234, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, -1);
    link = 1'b1;
    speed = 2'b10;
    duplex = 1'b1;
    frame(32, 2'b10, 5'd1, 5'd1, 16'h0, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd17, 16'h0, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd5, 16'h0, 6, -1);
    frame(32, 2'b10, 5'd1, 5'd17, 16'h0, 3, -1);
    frame(32, 2'b01, 5'd1, 5'd4, 16'hBEEF, -1, -1);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, 9);
    frame(32, 2'b10, 5'd1, 5'd4, 16'h0, -1, -1);
    for (int n = 0; n < 40; n++) begin
      link   = 1'($urandom);
      duplex = 1'($urandom);
      speed  = 2'($urandom_range(0, 2));
      pre    = $urandom_range(0, 7) == 0 ? 31 : 32;
      op     = $urandom_range(0, 7) == 0 ? 2'($urandom) : ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
      pa     = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'd1;
      ra     = ras[$urandom_range(0, 7)];
      wd     = 16'($urandom);
      flip   = $urandom_range(0, 3) == 0 ? int'($urandom_range(2, 17)) : -1;
      frame(pre, op, pa, ra, wd, flip, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
